// File: rtl/jt12_acc_mix_pkg.sv
// Shared definitions for the jt12 channel accumulator / stereo mixer.
//   slot_e       : operator slot encodings in frame order position (S1, S3, S2, S4)
//   NUM_CH_DEF   : default channel count per frame
//   ACC_W        : per-channel partial/total sum width
//   RUN_W        : running L/R mix width
//   carrier_mask : algorithm -> carrier mask, bit index = slot_e value
//   sat_mix      : clamp a running mix value to a signed w-bit range
package jt12_acc_mix_pkg;

    typedef enum logic [1:0] {
        SLOT_S1 = 2'd0,
        SLOT_S3 = 2'd1,
        SLOT_S2 = 2'd2,
        SLOT_S4 = 2'd3
    } slot_e;

    localparam int unsigned NUM_CH_DEF = 6;
    localparam int unsigned ACC_W      = 11;
    localparam int unsigned RUN_W      = 14;

    function automatic logic [3:0] carrier_mask(input logic [2:0] alg);
        logic [3:0] m;
        case (alg)
            3'd4:          m = 4'b1100;   // S2, S4
            3'd5, 3'd6:    m = 4'b1110;   // S3, S2, S4
            3'd7:          m = 4'b1111;   // all operators
            default:       m = 4'b1000;   // S4 only
        endcase
        return m;
    endfunction

    // w must not exceed RUN_W.
    function automatic logic signed [RUN_W-1:0] sat_mix(input logic signed [RUN_W-1:0] v,
                                                        input int unsigned w);
        int hi;
        int lo;
        int vi;
        hi = (1 << (w - 1)) - 1;
        lo = -hi - 1;
        vi = int'(v);
        if (vi > hi)
            return RUN_W'(hi);
        else if (vi < lo)
            return RUN_W'(lo);
        else
            return v;
    endfunction

endpackage

// File: rtl/jt12_sh_arst.sv
// Fixed-length shift register with asynchronous active-low clear.
//   clk   : clock, shifts every cycle
//   rst_n : asynchronous active-low clear of all stages
//   din   : W-bit input to stage 0
//   dout  : W-bit output of the last stage (din delayed by STAGES cycles)
module jt12_sh_arst #(
    parameter int unsigned W      = 11,
    parameter int unsigned STAGES = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] sr [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++)
                sr[i] <= '0;
        end else begin
            sr[0] <= din;
            for (int unsigned i = 1; i < STAGES; i++)
                sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[STAGES-1];

endmodule

// File: rtl/jt12_acc_mix.sv
// Channel accumulator and stereo mixer fed by the operator stage.
// One operator value per cycle, 24 slots per frame (S1, S3, S2, S4 groups of
// NUM_CH channels). Carrier operators are summed per channel, ch5 may be
// replaced by DAC data, and panned channel totals are mixed into L/R.
//   clk, rst_n          : clock, asynchronous active-low reset
//   zero                : current cycle is slot 0 (ch0 S1)
//   op_result [8:0]     : signed operator output of the current slot
//   alg [2:0]           : algorithm of the current slot's channel
//   pan_l, pan_r        : pan enables of the current slot's channel
//   dac_en, dac_data    : ch5 DAC substitution enable and signed sample
//   ch_sample/ch_idx    : registered channel total and its channel index
//   ch_valid            : one-cycle pulse with each channel total
//   left/right          : saturated signed MIX_W-bit mix, updated once per frame
//   mix_valid           : one-cycle pulse when left/right update
module jt12_acc_mix
    import jt12_acc_mix_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEF,
    parameter int unsigned MIX_W  = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    zero,
    input  logic signed [8:0]       op_result,
    input  logic [2:0]              alg,
    input  logic                    pan_l,
    input  logic                    pan_r,
    input  logic                    dac_en,
    input  logic signed [8:0]       dac_data,
    output logic signed [10:0]      ch_sample,
    output logic [2:0]              ch_idx,
    output logic                    ch_valid,
    output logic signed [MIX_W-1:0] left,
    output logic signed [MIX_W-1:0] right,
    output logic                    mix_valid
);

    logic [2:0]               ch_cnt;
    slot_e                    op_cnt;
    logic                     started;

    logic [2:0]               cur_ch;
    slot_e                    cur_op;
    logic [2:0]               nxt_ch;
    slot_e                    nxt_op;
    logic                     active;
    logic                     is_last_ch;
    logic                     is_s4;
    logic                     frame_end;

    logic [3:0]               mask;
    logic signed [ACC_W-1:0]  gated;
    logic signed [ACC_W-1:0]  sr_out;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  total;
    logic signed [RUN_W-1:0]  total_ext;

    logic signed [RUN_W-1:0]  run_l;
    logic signed [RUN_W-1:0]  run_r;
    logic signed [RUN_W-1:0]  run_l_nxt;
    logic signed [RUN_W-1:0]  run_r_nxt;

    // zero overrides the counters for the current cycle, so everything below
    // works on cur_* rather than the registered counts.
    always_comb begin
        cur_ch = zero ? 3'd0 : ch_cnt;
        cur_op = zero ? SLOT_S1 : op_cnt;
        active = started | zero;

        is_last_ch = (cur_ch == 3'(NUM_CH - 1));
        is_s4      = (cur_op == SLOT_S4);
        frame_end  = is_s4 && is_last_ch;

        nxt_ch = cur_ch + 3'd1;
        nxt_op = cur_op;
        if (is_last_ch) begin
            nxt_ch = '0;
            case (cur_op)
                SLOT_S1: nxt_op = SLOT_S3;
                SLOT_S3: nxt_op = SLOT_S2;
                SLOT_S2: nxt_op = SLOT_S4;
                default: nxt_op = SLOT_S1;
            endcase
        end
    end

    always_comb begin
        mask  = carrier_mask(alg);
        gated = mask[cur_op] ? {{(ACC_W-9){op_result[8]}}, op_result} : '0;

        // S1 starts a new channel sum; the stale shift-register value is dropped.
        if (cur_op == SLOT_S1)
            sum = gated;
        else
            sum = sr_out + gated;

        total = sum;
        if (is_last_ch && dac_en)
            total = {dac_data, 2'b00};

        total_ext = {{(RUN_W-ACC_W){total[ACC_W-1]}}, total};

        run_l_nxt = (cur_ch == 3'd0 && cur_op == SLOT_S1) ? '0 : run_l;
        run_r_nxt = (cur_ch == 3'd0 && cur_op == SLOT_S1) ? '0 : run_r;
        if (is_s4 && pan_l)
            run_l_nxt = run_l + total_ext;
        if (is_s4 && pan_r)
            run_r_nxt = run_r + total_ext;
    end

    jt12_sh_arst #(
        .W      (ACC_W),
        .STAGES (NUM_CH)
    ) u_sh (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sum),
        .dout  (sr_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt  <= '0;
            op_cnt  <= SLOT_S1;
            started <= 1'b0;
            run_l   <= '0;
            run_r   <= '0;
        end else begin
            ch_cnt  <= nxt_ch;
            op_cnt  <= nxt_op;
            started <= active;
            run_l   <= run_l_nxt;
            run_r   <= run_r_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_sample <= '0;
            ch_idx    <= '0;
            ch_valid  <= 1'b0;
        end else begin
            ch_valid <= is_s4 && active;
            if (is_s4) begin
                ch_sample <= total;
                ch_idx    <= cur_ch;
            end
        end
    end

    // Outputs only change for a frame that began on a real zero; a frame
    // truncated by an early zero never reaches frame_end, so left/right hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left      <= '0;
            right     <= '0;
            mix_valid <= 1'b0;
        end else begin
            mix_valid <= frame_end && active;
            if (frame_end && active) begin
                left  <= MIX_W'(sat_mix(run_l_nxt, MIX_W));
                right <= MIX_W'(sat_mix(run_r_nxt, MIX_W));
            end
        end
    end

endmodule

// File: tb/tb_jt12_acc_mix.sv
module tb_jt12_acc_mix;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              zero;
    logic signed [8:0] op_result;
    logic [2:0]        alg;
    logic              pan_l;
    logic              pan_r;
    logic              dac_en;
    logic signed [8:0] dac_data;
    logic signed [10:0] ch_sample;
    logic [2:0]        ch_idx;
    logic              ch_valid;
    logic signed [11:0] left;
    logic signed [11:0] right;
    logic              mix_valid;

    jt12_acc_mix #(.NUM_CH(6), .MIX_W(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .zero      (zero),
        .op_result (op_result),
        .alg       (alg),
        .pan_l     (pan_l),
        .pan_r     (pan_r),
        .dac_en    (dac_en),
        .dac_data  (dac_data),
        .ch_sample (ch_sample),
        .ch_idx    (ch_idx),
        .ch_valid  (ch_valid),
        .left      (left),
        .right     (right),
        .mix_valid (mix_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] alg;
        int         s1, s3, s2, s4;
        logic [5:0] pl, pr;
        logic       den;
        int         dac;
        int         ch_exp;
        int         ch5_exp;
        int         l_exp, r_exp;
    } vec_t;

    vec_t vecs[7];
    int total_cnt = 0;
    int bad_cnt   = 0;
    int hold_l    = 0;
    int hold_r    = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act != exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_slot(input vec_t v, input int s, input logic z);
        int ch;
        int op;
        int val;
        ch  = s % 6;
        op  = s / 6;
        val = (op == 0) ? v.s1 : (op == 1) ? v.s3 : (op == 2) ? v.s2 : v.s4;
        zero      = z;
        op_result = 9'(val);
        alg       = v.alg;
        pan_l     = v.pl[ch];
        pan_r     = v.pr[ch];
        dac_en    = v.den;
        dac_data  = 9'(v.dac);
    endtask

    // Runs nslots slots of a frame starting with zero at slot 0 and checks
    // the outputs after every slot.
    task automatic run_frame(input vec_t v, input int nslots);
        int ch;
        int op;
        for (int s = 0; s < nslots; s++) begin
            ch = s % 6;
            op = s / 6;
            drive_slot(v, s, s == 0);
            @(posedge clk);
            #1;
            chk("ch_valid", int'(ch_valid), (op == 3) ? 1 : 0);
            if (op == 3) begin
                chk("ch_idx", int'(ch_idx), ch);
                chk("ch_sample", int'(ch_sample), (ch == 5) ? v.ch5_exp : v.ch_exp);
            end
            chk("mix_valid", int'(mix_valid), (s == 23) ? 1 : 0);
            if (s == 23) begin
                hold_l = v.l_exp;
                hold_r = v.r_exp;
            end
            chk("left", int'(left), hold_l);
            chk("right", int'(right), hold_r);
        end
    endtask

    initial begin
        // alg, s1, s3, s2, s4, pan_l, pan_r, dac_en, dac, ch, ch5, left, right
        vecs[0] = '{3'd7, 10, 10, 10, 10, 6'h3F, 6'h3F, 1'b0, 0, 40, 40, 240, 240};
        vecs[1] = '{3'd0, 100, 100, 100, -5, 6'h3F, 6'h3F, 1'b0, 0, -5, -5, -30, -30};
        vecs[2] = '{3'd7, 255, 255, 255, 255, 6'h3F, 6'h3F, 1'b0, 0, 1020, 1020, 2047, 2047};
        vecs[3] = '{3'd7, -256, -256, -256, -256, 6'h3F, 6'h3F, 1'b0, 0, -1024, -1024, -2048, -2048};
        vecs[4] = '{3'd7, 1, 1, 1, 1, 6'h20, 6'h00, 1'b1, -3, 4, -12, -12, 0};
        vecs[5] = '{3'd4, 7, 11, 20, 3, 6'h03, 6'h04, 1'b0, 0, 23, 23, 46, 23};
        vecs[6] = '{3'd5, 7, 11, 20, 3, 6'h00, 6'h21, 1'b1, 100, 34, 400, 0, 434};

        rst_n = 1'b0;
        zero = 1'b0; op_result = '0; alg = '0; pan_l = 1'b0; pan_r = 1'b0;
        dac_en = 1'b0; dac_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ch_sample", int'(ch_sample), 0);
        chk("reset ch_valid", int'(ch_valid), 0);
        chk("reset mix_valid", int'(mix_valid), 0);
        chk("reset left", int'(left), 0);
        chk("reset right", int'(right), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_frame(vecs[i], 24);

        // Truncated frame: zero again at slot 12, then a full frame.
        run_frame(vecs[0], 12);
        run_frame(vecs[0], 24);

        // Mid-frame reset at slot 17.
        run_frame(vecs[1], 17);
        drive_slot(vecs[1], 17, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst ch_sample", int'(ch_sample), 0);
        chk("async rst ch_idx", int'(ch_idx), 0);
        chk("async rst ch_valid", int'(ch_valid), 0);
        chk("async rst left", int'(left), 0);
        chk("async rst right", int'(right), 0);
        hold_l = 0;
        hold_r = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        // No zero yet: internal counters wrap through a whole frame, no pulses.
        for (int s = 0; s < 30; s++) begin
            drive_slot(vecs[2], (s + 5) % 24, 1'b0);
            @(posedge clk);
            #1;
            chk("pre-zero ch_valid", int'(ch_valid), 0);
            chk("pre-zero mix_valid", int'(mix_valid), 0);
            chk("pre-zero left", int'(left), 0);
        end
        run_frame(vecs[2], 24);
        run_frame(vecs[5], 24);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
